pci_target_bank: RTL and testbench

Parametrised 32-bit PCI bus target exposing a DEPTH-word byte-addressable memory bank at a configurable base address. It decodes I/O and memory read/write commands, handles single and burst data phases with byte enables, inserts programmable read wait states and supports target-initiated disconnect at the end of the bank. It sits on the shared multiplexed AD bus beside other targets and the initiator model.

---
 rtl/pci_tgt_pkg.sv | 38 +++
 rtl/pci_tgt_mem.sv | 33 +++
 rtl/pci_target_bank.sv | 177 +++++++++++++++++
 tb/tb_pci_target_bank.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_tgt_pkg.sv
// rtl/pci_tgt_pkg.sv - shared types and constants for the PCI target bank
//
// Contents: bus command codes, target FSM state enum, cycle-type enum and
// the command-to-cycle decoder used during the address phase.
package pci_tgt_pkg;

    localparam logic [3:0] CMD_IO_READ   = 4'b0010;
    localparam logic [3:0] CMD_IO_WRITE  = 4'b0011;
    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WRITE,
        ST_RD_TURN,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_BACKOFF,
        ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        CYC_NONE,
        CYC_READ,
        CYC_WRITE
    } cyc_t;

    // I/O and memory space share the same bank; only direction matters.
    function automatic cyc_t decode_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_IO_READ, CMD_MEM_READ:   decode_cmd = CYC_READ;
            CMD_IO_WRITE, CMD_MEM_WRITE: decode_cmd = CYC_WRITE;
            default:                     decode_cmd = CYC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pci_tgt_mem.sv
// rtl/pci_tgt_mem.sv - DEPTH x 32 RAM with byte-lane write enables
//
// Ports:
//   clk    in   write clock
//   we     in   per-byte write enable, lane i = bits [8i+7:8i]
//   addr   in   word index shared by read and write
//   wdata  in   write data
//   rdata  out  asynchronous read of ram[addr]
// Contents are not reset.
module pci_tgt_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                ram[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = ram[addr];

endmodule

// File: rtl/pci_target_bank.sv
// rtl/pci_target_bank.sv - 32-bit PCI target exposing a DEPTH-word memory bank
//
// Parameters: BASE_ADDR (byte base, DEPTH*4 aligned), DEPTH (words, power of
// two), READ_WAIT (extra cycles before each read data phase, 0..7).
// Ports:
//   clk       in     bus clock
//   rst       in     synchronous active-low reset
//   frame_n   in     FRAME#
//   irdy_n    in     IRDY#
//   cbe_n     in     command (address phase) / byte enables (data phases)
//   ad        inout  multiplexed address/data, driven only in read data phases
//   trdy_n    out    TRDY#
//   devsel_n  out    DEVSEL# (medium decode)
//   stop_n    out    STOP#
// Build option: PCI_TGT_STOP_EN enables disconnect-with-data on the last word
// of the bank; otherwise bursts wrap to word 0 and stop_n stays high.
module pci_target_bank
    import pci_tgt_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter int          READ_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_n,
    input  logic       irdy_n,
    input  logic [3:0] cbe_n,
    inout  wire [31:0] ad,
    output logic       trdy_n,
    output logic       devsel_n,
    output logic       stop_n
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WAIT_INIT = (READ_WAIT > 0) ? 3'(READ_WAIT - 1) : 3'd0;
`ifdef PCI_TGT_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    state_t        state_q, state_d;
    cyc_t          cyc_q, cyc_d;
    logic [AW-1:0] index_q, index_d;
    logic [2:0]    wait_q, wait_d;
    // Set after a disconnect-with-data: wait for the initiator to drop FRAME#.
    logic          hold_q, hold_d;

    logic          ad_oe;
    logic [3:0]    mem_we;
    logic [31:0]   rd_data;
    logic          addr_hit;
    logic          last_word;

    assign addr_hit  = (ad[31:AW+2] == BASE_ADDR[31:AW+2]) && (ad[1:0] == 2'b00);
    assign last_word = &index_q;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        index_d  = index_q;
        wait_d   = wait_q;
        hold_d   = hold_q;
        trdy_n   = 1'b1;
        devsel_n = 1'b1;
        stop_n   = 1'b1;
        ad_oe    = 1'b0;
        mem_we   = 4'h0;
        case (state_q)
            ST_IDLE: begin
                if (!frame_n) begin
                    state_d = ST_DECODE;
                    index_d = ad[AW+1:2];
                    cyc_d   = addr_hit ? decode_cmd(cbe_n) : CYC_NONE;
                end
            end
            ST_DECODE: begin
                case (cyc_q)
                    CYC_WRITE: state_d = ST_WRITE;
                    CYC_READ:  state_d = ST_RD_TURN;
                    default:   state_d = ST_IGNORE;
                endcase
            end
            ST_RD_TURN: begin
                devsel_n = 1'b0;
                if (READ_WAIT > 0) begin
                    state_d = ST_RD_WAIT;
                    wait_d  = WAIT_INIT;
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_WAIT: begin
                devsel_n = 1'b0;
                if (wait_q == 3'd0) begin
                    state_d = ST_RD_DATA;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ST_WRITE, ST_RD_DATA: begin
                devsel_n = 1'b0;
                if (hold_q) begin
                    stop_n = 1'b0;
                    if (frame_n) begin
                        state_d = ST_BACKOFF;
                    end
                end else begin
                    trdy_n = 1'b0;
                    ad_oe  = (state_q == ST_RD_DATA);
                    if (STOP_EN && last_word && !frame_n) begin
                        stop_n = 1'b0;
                    end
                    if (!irdy_n) begin
                        index_d = index_q + AW'(1);
                        if (state_q == ST_WRITE) begin
                            mem_we = ~cbe_n;
                        end
                        if (frame_n) begin
                            state_d = ST_BACKOFF;
                        end else if (STOP_EN && last_word) begin
                            hold_d = 1'b1;
                        end else if (state_q == ST_RD_DATA && READ_WAIT > 0) begin
                            state_d = ST_RD_WAIT;
                            wait_d  = WAIT_INIT;
                        end
                    end
                end
            end
            ST_BACKOFF: begin
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_IGNORE: begin
                if (frame_n && irdy_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A reset edge must never commit a write.
        if (!rst) begin
            mem_we = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= CYC_NONE;
            index_q <= '0;
            wait_q  <= 3'd0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            index_q <= index_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
        end
    end

    pci_tgt_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (index_q),
        .wdata (ad),
        .rdata (rd_data)
    );

    assign ad = ad_oe ? rd_data : 32'bz;

endmodule

// File: tb/tb_pci_target_bank.sv
// tb/tb_pci_target_bank.sv - directed self-checking bench for pci_target_bank
module tb_pci_target_bank;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;
    localparam int          RW    = 1;
`ifdef PCI_TGT_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_n = 1'b1;
    logic        irdy_n = 1'b1;
    logic [3:0]  cbe_n = 4'hF;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_ad = 32'h0;
    wire  [31:0] ad;
    logic        trdy_n, devsel_n, stop_n;

    assign ad = tb_oe ? tb_ad : 32'bz;

    always #5 clk = ~clk;

    pci_target_bank #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .READ_WAIT (RW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .frame_n  (frame_n),
        .irdy_n   (irdy_n),
        .cbe_n    (cbe_n),
        .ad       (ad),
        .trdy_n   (trdy_n),
        .devsel_n (devsel_n),
        .stop_n   (stop_n)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_done = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] wd [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic end_cycle();
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        tb_oe   = 1'b0;
        cbe_n   = 4'hF;
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic [3:0] cmd);
        frame_n = 1'b0;
        irdy_n  = 1'b1;
        cbe_n   = cmd;
        tb_ad   = addr;
        tb_oe   = 1'b1;
        tick();
    endtask

    task automatic check_released(input string tag);
        check({tag, "_trdy"}, 32'(trdy_n), 32'd1);
        check({tag, "_devsel"}, 32'(devsel_n), 32'd1);
        check({tag, "_stop"}, 32'(stop_n), 32'd1);
        check({tag, "_adz"}, 32'(dut.ad_oe), 32'd0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] cmd,
                               input int n, input logic [3:0] be);
        int idx;
        int cnt;
        bit stopped;
        idx = int'((addr - BASE) >> 2) % DEPTH;
        stopped = 1'b0;
        n_done = 0;
        addr_phase(addr, cmd);
        for (int i = 0; i < n; i++) begin
            frame_n = (i == n - 1);
            irdy_n  = 1'b0;
            cbe_n   = be;
            tb_ad   = wd[i];
            cnt = 0;
            while (trdy_n !== 1'b0 && cnt < 16) begin
                tick();
                cnt++;
            end
            check("wr_latency", 32'(cnt), (i == 0) ? 32'd1 : 32'd0);
            if (cnt >= 16) begin
                end_cycle();
                tick();
                return;
            end
            check("wr_devsel", 32'(devsel_n), 32'd0);
            check("wr_stop", 32'(stop_n),
                  (STOP_EN && idx == DEPTH - 1 && i != n - 1) ? 32'd0 : 32'd1);
            stopped = (stop_n === 1'b0);
            tick();
            for (int l = 0; l < 4; l++) begin
                if (!be[l]) model[idx][8*l +: 8] = wd[i][8*l +: 8];
            end
            n_done++;
            idx = (idx + 1) % DEPTH;
            if (stopped) begin
                check("disc_trdy", 32'(trdy_n), 32'd1);
                check("disc_stop", 32'(stop_n), 32'd0);
                break;
            end
        end
        if (stopped) begin
            end_cycle();
            tick();
        end
        end_cycle();
        check_released("wr_backoff");
        tick();
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] cmd,
                              input int n, input int stall_at);
        int cnt;
        bit stopped;
        logic [31:0] expv;
        addr_phase(addr, cmd);
        tb_oe   = 1'b0;
        cbe_n   = 4'h0;
        irdy_n  = 1'b0;
        frame_n = (n == 1);
        check("rd_turn_noad", 32'(dut.ad_oe), 32'd0);
        for (int i = 0; i < n; i++) begin
            frame_n = (i == n - 1);
            cnt = 0;
            while (trdy_n !== 1'b0 && cnt < 16) begin
                tick();
                cnt++;
                if (trdy_n !== 1'b0) check("rd_wait_noad", 32'(dut.ad_oe), 32'd0);
            end
            check("rd_latency", 32'(cnt), (i == 0) ? 32'(2 + RW) : 32'(RW));
            if (cnt >= 16) begin
                end_cycle();
                tick();
                return;
            end
            if (exp_q.size() > 0) expv = exp_q.pop_front();
            else expv = 32'hBAD0_BAD0;
            check("rd_data", ad, expv);
            check("rd_devsel", 32'(devsel_n), 32'd0);
            if (i == stall_at) begin
                irdy_n = 1'b1;
                tick();
                check("stall_trdy", 32'(trdy_n), 32'd0);
                check("stall_ad", ad, expv);
                irdy_n = 1'b0;
            end
            stopped = (stop_n === 1'b0);
            tick();
            if (stopped) begin
                end_cycle();
                tick();
                break;
            end
        end
        end_cycle();
        check_released("rd_backoff");
        tick();
    endtask

    task automatic miss_cycle(input logic [31:0] addr, input logic [3:0] cmd);
        addr_phase(addr, cmd);
        frame_n = 1'b1;
        irdy_n  = 1'b0;
        cbe_n   = 4'h0;
        tb_ad   = 32'hA5A5_A5A5;
        for (int k = 0; k < 4; k++) begin
            check_released("miss");
            tick();
        end
        end_cycle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        // reset state
        rst = 1'b0;
        tick();
        tick();
        check_released("reset");
        rst = 1'b1;
        tick();

        // single write / read back
        wd[0] = 32'hDEAD_BEEF;
        write_burst(BASE + 32'd4, 4'b0111, 1, 4'b0000);
        exp_q.push_back(32'hDEAD_BEEF);
        read_burst(BASE + 32'd4, 4'b0110, 1, -1);

        // byte enables over an all-ones word, via I/O space
        wd[0] = 32'hFFFF_FFFF;
        write_burst(BASE + 32'd8, 4'b0011, 1, 4'b0000);
        wd[0] = 32'h1122_3344;
        write_burst(BASE + 32'd8, 4'b0111, 1, 4'b1010);
        exp_q.push_back(32'hFF22_FF44);
        read_burst(BASE + 32'd8, 4'b0010, 1, -1);

        // 4-word burst write and read with a mid-burst initiator stall
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        write_burst(BASE, 4'b0111, 4, 4'b0000);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
        read_burst(BASE, 4'b0110, 4, 2);

        // out-of-range address and unsupported command
        miss_cycle(BASE + 32'(DEPTH * 4), 4'b0111);
        miss_cycle(BASE, 4'b0001);
        exp_q.push_back(32'd2);
        read_burst(BASE + 32'd4, 4'b0110, 1, -1);

        // 6-word burst from word 2: wrap or disconnect at end of bank
        for (int i = 0; i < 6; i++) wd[i] = 32'h60 + 32'(i);
        write_burst(BASE + 32'd8, 4'b0111, 6, 4'b0000);
        check("wrap_count", 32'(n_done), STOP_EN ? 32'd2 : 32'd6);
        if (STOP_EN) begin
            exp_q.push_back(32'd1);
            exp_q.push_back(32'd2);
            exp_q.push_back(32'h60);
            exp_q.push_back(32'h61);
        end else begin
            exp_q.push_back(32'h62);
            exp_q.push_back(32'h63);
            exp_q.push_back(32'h64);
            exp_q.push_back(32'h65);
        end
        read_burst(BASE, 4'b0110, 4, -1);

        // reset in the middle of a read burst
        addr_phase(BASE, 4'b0110);
        tb_oe   = 1'b0;
        cbe_n   = 4'h0;
        irdy_n  = 1'b0;
        frame_n = 1'b0;
        cnt = 0;
        while (trdy_n !== 1'b0 && cnt < 16) begin
            tick();
            cnt++;
        end
        check("rst_rd_latency", 32'(cnt), 32'(2 + RW));
        tick();
        rst = 1'b0;
        tick();
        check_released("rst_mid");
        rst = 1'b1;
        end_cycle();
        tick();
        check_released("rst_after");
        exp_q.push_back(model[2]);
        read_burst(BASE + 32'd8, 4'b0110, 1, -1);
        wd[0] = 32'hA5A5_5A5A;
        write_burst(BASE + 32'd12, 4'b0111, 1, 4'b0000);
        exp_q.push_back(32'hA5A5_5A5A);
        read_burst(BASE + 32'd12, 4'b0110, 1, -1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
